// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, mux selects.
package multicycle_controller_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  // Controller states; codes 11-15 are unused and recover to FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Opcodes, shared with the single-cycle main decoder.
  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

  // ALU-decoder class handed to the external ALU decoder.
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // Result mux select.
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  // Immediate format select.
  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  // ALU operand selects.
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_RD2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  // Per-state control bundle produced by mc_state_outputs.
  typedef struct packed {
    logic             pcupdate;
    logic             branch;
    logic             adrsrc;
    logic             irwrite;
    logic             memwrite;
    logic             regwrite;
    logic [SEL_W-1:0] alusrca;
    logic [SEL_W-1:0] alusrcb;
    logic [SEL_W-1:0] resultsrc;
    logic [SEL_W-1:0] aluop;
  } ctrl_t;

  // Immediate format depends only on the opcode, independent of state.
  function automatic logic [SEL_W-1:0] imm_decode(input logic [OP_W-1:0] op);
    logic [SEL_W-1:0] imm;
    imm = IMM_I;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_state_outputs.sv
// Moore output decode: maps the current state to the control bundle.
module mc_state_outputs
  import multicycle_controller_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control values; anything not listed stays deasserted.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // IR and PC load only once the fetch completes, so a stall never
        // advances the PC.
        ctrl.adrsrc    = 1'b0;
        ctrl.irwrite   = mem_ready;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.pcupdate  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        // Held for the whole stall until memory accepts the write.
        ctrl.adrsrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_RD2;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regwrite  = 1'b1;
      end
      S_JAL: begin
        ctrl.alusrca  = SRCA_OLDPC;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.pcupdate = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_RD2;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: state register, next-state decode and
// reset gating of the write strobes.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             adrsrc,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic [SEL_W-1:0] alusrca,
  output logic [SEL_W-1:0] alusrcb,
  output logic [SEL_W-1:0] resultsrc,
  output logic [SEL_W-1:0] aluop,
  output logic [SEL_W-1:0] immsrc,
  output logic             illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   illegal_c;

  // State register; reset overrides any stall or in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the unsupported-opcode flag raised in DECODE.
  always_comb begin
    state_next = S_FETCH;
    illegal_c  = 1'b0;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            state_next = S_FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Per-state control values.
  mc_state_outputs u_state_outputs (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Write strobes are killed while reset is held so an abandoned
  // instruction cannot touch architectural state.
  assign pcwrite   = ~rst & (ctrl.pcupdate | (ctrl.branch & zero));
  assign irwrite   = ~rst & ctrl.irwrite;
  assign memwrite  = ~rst & ctrl.memwrite;
  assign regwrite  = ~rst & ctrl.regwrite;
  assign illegal   = ~rst & illegal_c;

  assign adrsrc    = ctrl.adrsrc;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign resultsrc = ctrl.resultsrc;
  assign aluop     = ctrl.aluop;
  assign immsrc    = imm_decode(op);
  assign state_dbg = STATE_W'(state);

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port op, input, 7 bits: opcode field of the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: unified memory has completed the current access.
REQ-006 SHALL have port pcwrite, output, 1 bit: PC register enable.
REQ-007 SHALL have port adrsrc, output, 1 bit: memory address select; 0 selects PC, 1 selects ALU result register.
REQ-008 SHALL have port irwrite, output, 1 bit: instruction register and old-PC register enable.
REQ-009 SHALL have port memwrite, output, 1 bit: memory write strobe.
REQ-010 SHALL have port regwrite, output, 1 bit: register file write enable.
REQ-011 SHALL have ports alusrca and alusrcb, outputs, 2 bits each: ALU operand selects.
REQ-012 SHALL have ports resultsrc, aluop and immsrc, outputs, 2 bits each: result mux select, ALU-decoder class, immediate format.
REQ-013 SHALL have port illegal, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-014 SHALL have port state_dbg, output, 4 bits: current state encoding.

Function
REQ-015 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 SHALL return to FETCH.
REQ-016 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-017 DECODE SHALL transition by op as follows:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1101111 -> JAL.
- 1100011 -> BEQ.
- any other opcode -> FETCH, with illegal=1 for that one cycle.
REQ-018 MEMADR SHALL go to MEMREAD when op=0000011 and to MEMWRITE otherwise.
REQ-019 MEMREAD SHALL hold until mem_ready=1, then go to MEMWB; MEMWRITE SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 MEMWB, BEQ and ALUWB SHALL go to FETCH; EXECUTER, EXECUTEI and JAL SHALL go to ALUWB.
REQ-021 Per-state outputs (alusrca, alusrcb, aluop, resultsrc as 2-bit binary; all unlisted outputs 0):
- FETCH: adrsrc=0, irwrite=mem_ready, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=mem_ready.
- DECODE: alusrca=01, alusrcb=01.
- MEMADR: alusrca=10, alusrcb=01.
- MEMREAD: adrsrc=1.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, memwrite=1.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: resultsrc=00, regwrite=1.
- JAL: alusrca=01, alusrcb=10, pcupdate=1.
- BEQ: alusrca=10, alusrcb=00, aluop=01, branch=1.
REQ-022 pcwrite SHALL equal pcupdate OR (branch AND zero), combinationally from state and zero.
REQ-023 immsrc SHALL be combinational from op in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
REQ-024 In a stalled FETCH, irwrite and pcwrite SHALL remain 0, so the PC advances exactly once per fetch.
REQ-025 In a stalled MEMWRITE, memwrite SHALL remain 1 and adrsrc SHALL remain 1 until mem_ready=1.
REQ-026 Instruction latency SHALL be, with mem_ready=1 throughout: lw 5 cycles; sw, R-type, I-type ALU and jal 4 cycles; beq 3 cycles. Each stall cycle SHALL add exactly one cycle.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be FETCH, regardless of the current state or any stall.
REQ-028 While rst=1, pcwrite, irwrite, memwrite, regwrite and illegal SHALL be forced to 0 combinationally.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction with no further register or memory write.
REQ-030 After rst deasserts, the first FETCH SHALL behave as a normal fetch.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the opcode constants (shared with the single-cycle main decoder) and the aluop, resultsrc and immsrc encodings.
REQ-032 One sub-module, mc_state_outputs, SHALL map state to control outputs combinationally; the next-state logic and state register SHALL stay in multicycle_controller.
REQ-033 The ALU-control decode SHALL remain outside this block in the existing ALU decoder.

Verification
REQ-034 Reset: rst=1 for 2 cycles while in MEMWRITE -> state_dbg=0 and memwrite=0 during reset; first cycle after reset asserts irwrite=1 when mem_ready=1.
REQ-035 lw, op=0000011, mem_ready=1 -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4; resultsrc=01 in state 4.
REQ-036 beq, op=1100011: zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0; both cases return to FETCH after 3 cycles.
REQ-037 Stall: mem_ready=0 for 3 cycles in FETCH, then 1 -> irwrite and pcwrite each pulse exactly once; state_dbg stays 0 for 3 cycles.
REQ-038 sw with mem_ready low for 2 cycles in MEMWRITE -> memwrite=1 for 3 consecutive cycles, immsrc=01 throughout, then FETCH.
REQ-039 Illegal opcode 1111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no regwrite or memwrite asserted.
